// File: rtl/cdp1802_pkg.sv
// Shared state codes, default machine-cycle timing and the S-state decision rule
// for the CDP1802 DMA/interrupt sequencer.
package cdp1802_pkg;

    localparam logic [1:0] SC_FETCH = 2'd0;
    localparam logic [1:0] SC_EXEC  = 2'd1;
    localparam logic [1:0] SC_DMA   = 2'd2;
    localparam logic [1:0] SC_INT   = 2'd3;

    localparam int unsigned CYCLE_CLKS_DEF = 8;
    localparam int unsigned TPA_PHASE_DEF  = 1;
    localparam int unsigned TPB_PHASE_DEF  = 6;

    // Next machine cycle from the requests sampled at TPB. DMA beats interrupt; the
    // init cycle after reset may only go to S2 or S0.
    function automatic logic [1:0] sc_next(input logic [1:0] sc,
                                           input logic       init,
                                           input logic       dma,
                                           input logic       intr,
                                           input logic       idle,
                                           input logic       last);
        if (init) begin
            return dma ? SC_DMA : SC_FETCH;
        end
        unique case (sc)
            SC_FETCH: return SC_EXEC;
            SC_EXEC: begin
                if (dma)                return SC_DMA;
                else if (intr)          return SC_INT;
                else if (idle || !last) return SC_EXEC;
                else                    return SC_FETCH;
            end
            SC_DMA: begin
                if (dma)       return SC_DMA;
                else if (intr) return SC_INT;
                else if (idle) return SC_EXEC;
                else           return SC_FETCH;
            end
            SC_INT: return dma ? SC_DMA : SC_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/cdp1802_timing_gen.sv
// Machine-cycle phase counter with registered TPA/TPB pulses and a wrap strobe
// marking the last clock of each machine cycle.
module cdp1802_timing_gen #(
    parameter int unsigned CycleClks = 8,
    parameter int unsigned TpaPhase  = 1,
    parameter int unsigned TpbPhase  = 6,
    localparam int unsigned PW       = $clog2(CycleClks)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clock_en_i,
    output logic [PW-1:0] phase_o,
    output logic [PW-1:0] phase_next_o,
    output logic          wrap_o,
    output logic          tpa_o,
    output logic          tpb_o
);

    localparam logic [PW-1:0] LastPh = PW'(CycleClks - 1);
    localparam logic [PW-1:0] TpaPh  = PW'(TpaPhase);
    localparam logic [PW-1:0] TpbPh  = PW'(TpbPhase);

    logic [PW-1:0] phase_q, phase_d;
    logic          tpa_q, tpb_q;
    logic          wrap;

    assign wrap = clock_en_i && (phase_q == LastPh);

    always_comb begin
        phase_d = phase_q;
        if (clock_en_i) begin
            phase_d = wrap ? '0 : phase_q + PW'(1);
        end
    end

    // Pulses fire only on the clock a phase is entered, so a slow clock_en gives one-clock pulses.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            phase_q <= '0;
            tpa_q   <= 1'b0;
            tpb_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            tpa_q   <= clock_en_i && (phase_d == TpaPh);
            tpb_q   <= clock_en_i && (phase_d == TpbPh);
        end
    end

    assign phase_o      = phase_q;
    assign phase_next_o = phase_d;
    assign wrap_o       = wrap;
    assign tpa_o        = tpa_q;
    assign tpb_o        = tpb_q;

endmodule

// File: rtl/cdp1802_dma_sequencer.sv
// CPU-side S0/S1/S2/S3 sequencer: arbitrates DMA-in/DMA-out/interrupt at cycle boundaries
// and runs the S2 memory transfer at R0 and the S3 interrupt-entry handshake.
module cdp1802_dma_sequencer
    import cdp1802_pkg::*;
#(
    parameter int unsigned CYCLE_CLKS = CYCLE_CLKS_DEF,
    parameter int unsigned TPA_PHASE  = TPA_PHASE_DEF,
    parameter int unsigned TPB_PHASE  = TPB_PHASE_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clock_en_i,
    input  logic        dmao_n_i,
    input  logic        dmai_n_i,
    input  logic        int_n_i,
    input  logic        ie_i,
    input  logic        exec_last_i,
    input  logic        idle_i,
    input  logic [15:0] r0_i,
    input  logic [7:0]  dma_wdata_i,
    input  logic [7:0]  mem_rdata_i,
    output logic        tpa_o,
    output logic        tpb_o,
    output logic [1:0]  sc_o,
    output logic [15:0] mem_addr_o,
    output logic        mem_rd_o,
    output logic        mem_wr_o,
    output logic [7:0]  mem_wdata_o,
    output logic [7:0]  dma_rdata_o,
    output logic        r0_inc_o,
    output logic        int_ack_o,
    output logic        ie_clear_o
);

    localparam int unsigned   PW     = $clog2(CYCLE_CLKS);
    localparam logic [PW-1:0] LastPh = PW'(CYCLE_CLKS - 1);
    localparam logic [PW-1:0] TpaPh  = PW'(TPA_PHASE);
    localparam logic [PW-1:0] TpbPh  = PW'(TPB_PHASE);

    logic [PW-1:0] phase, phase_next;
    logic          wrap, tpa_strobe, tpb_strobe;

    cdp1802_timing_gen #(
        .CycleClks (CYCLE_CLKS),
        .TpaPhase  (TPA_PHASE),
        .TpbPhase  (TPB_PHASE)
    ) u_timing (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clock_en_i   (clock_en_i),
        .phase_o      (phase),
        .phase_next_o (phase_next),
        .wrap_o       (wrap),
        .tpa_o        (tpa_o),
        .tpb_o        (tpb_o)
    );

    assign tpa_strobe = clock_en_i && (phase == TpaPh);
    assign tpb_strobe = clock_en_i && (phase == TpbPh);

    logic [1:0]  sc_q, sc_d;
    logic        init_q, init_d;
    logic        dir_in_q, dir_in_d;
    logic        req_in_q, req_out_q, int_q, idle_q, last_q;
    logic [15:0] mem_addr_q;
    logic [7:0]  mem_wdata_q, dma_rdata_q;
    logic        mem_rd_q, mem_wr_q, r0_inc_q, int_ack_q;
    logic        mem_rd_d, mem_wr_d, r0_inc_d, int_ack_d;

    // Direction is chosen only at the wrap, so a request dropping mid-S2 cannot change it.
    always_comb begin
        sc_d     = sc_q;
        init_d   = init_q;
        dir_in_d = dir_in_q;
        if (wrap) begin
            sc_d     = sc_next(sc_q, init_q, req_in_q | req_out_q, int_q, idle_q, last_q);
            init_d   = 1'b0;
            dir_in_d = req_in_q;
        end
        mem_rd_d  = (sc_d == SC_DMA) && !dir_in_d &&
                    (phase_next >= PW'(2)) && (phase_next <= TpbPh);
        mem_wr_d  = (sc_d == SC_DMA) && dir_in_d && (phase_next == TpbPh);
        r0_inc_d  = clock_en_i && (sc_d == SC_DMA) && (phase_next == LastPh);
        int_ack_d = clock_en_i && (sc_d == SC_INT) && (phase_next == LastPh);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sc_q        <= SC_EXEC;
            init_q      <= 1'b1;
            dir_in_q    <= 1'b0;
            req_in_q    <= 1'b0;
            req_out_q   <= 1'b0;
            int_q       <= 1'b0;
            idle_q      <= 1'b0;
            last_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            dma_rdata_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            r0_inc_q    <= 1'b0;
            int_ack_q   <= 1'b0;
        end else begin
            sc_q      <= sc_d;
            init_q    <= init_d;
            dir_in_q  <= dir_in_d;
            mem_rd_q  <= mem_rd_d;
            mem_wr_q  <= mem_wr_d;
            r0_inc_q  <= r0_inc_d;
            int_ack_q <= int_ack_d;
            if (tpb_strobe) begin
                req_in_q  <= !dmai_n_i;
                req_out_q <= !dmao_n_i;
                int_q     <= !int_n_i && ie_i;
                idle_q    <= idle_i;
                last_q    <= exec_last_i;
            end
            if (sc_q == SC_DMA && phase == '0) begin
                mem_addr_q <= r0_i;
            end
            if (sc_q == SC_DMA && dir_in_q && tpa_strobe) begin
                mem_wdata_q <= dma_wdata_i;
            end
            if (sc_q == SC_DMA && !dir_in_q && tpb_strobe) begin
                dma_rdata_q <= mem_rdata_i;
            end
        end
    end

    assign sc_o        = sc_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_rd_o    = mem_rd_q;
    assign mem_wr_o    = mem_wr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign dma_rdata_o = dma_rdata_q;
    assign r0_inc_o    = r0_inc_q;
    assign int_ack_o   = int_ack_q;
    assign ie_clear_o  = int_ack_q;

endmodule

// File: tb/tb_cdp1802_dma_sequencer.sv
// Bench for cdp1802_dma_sequencer: directed scenarios with literal expectations, then
// randomized traffic compared every clock against a cycle-level behavioural model.
module tb_cdp1802_dma_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clock_en = 1'b1;
    logic        dmao_n = 1'b1, dmai_n = 1'b1, int_n = 1'b1;
    logic        ie = 1'b0, exec_last = 1'b1, idle = 1'b0;
    logic [15:0] r0 = '0;
    logic [7:0]  dma_wdata = '0, mem_rdata = '0;

    logic        tpa, tpb, mem_rd, mem_wr, r0_inc, int_ack, ie_clear;
    logic [1:0]  sc;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, dma_rdata;

    cdp1802_dma_sequencer dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clock_en_i  (clock_en),
        .dmao_n_i    (dmao_n),
        .dmai_n_i    (dmai_n),
        .int_n_i     (int_n),
        .ie_i        (ie),
        .exec_last_i (exec_last),
        .idle_i      (idle),
        .r0_i        (r0),
        .dma_wdata_i (dma_wdata),
        .mem_rdata_i (mem_rdata),
        .tpa_o       (tpa),
        .tpb_o       (tpb),
        .sc_o        (sc),
        .mem_addr_o  (mem_addr),
        .mem_rd_o    (mem_rd),
        .mem_wr_o    (mem_wr),
        .mem_wdata_o (mem_wdata),
        .dma_rdata_o (dma_rdata),
        .r0_inc_o    (r0_inc),
        .int_ack_o   (int_ack),
        .ie_clear_o  (ie_clear)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 0;

    // Behavioural model: machine cycle number, phase count and the requests seen at TPB.
    int        m_ph = 0, m_sc = 1, nsc = 0;
    bit        m_init = 1, m_dir_in = 0, adv = 0;
    bit        p_in = 0, p_out = 0, p_int = 0, p_idle = 0, p_last = 0;
    bit [15:0] m_addr = 0;
    bit [7:0]  m_wdata = 0, m_rdata = 0;
    bit        e_tpa = 0, e_tpb = 0, e_rd = 0, e_wr = 0, e_inc = 0, e_ack = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ph = 0; m_sc = 1; m_init = 1; m_dir_in = 0;
            p_in = 0; p_out = 0; p_int = 0; p_idle = 0; p_last = 0;
            m_addr = 0; m_wdata = 0; m_rdata = 0;
            e_tpa = 0; e_tpb = 0; e_rd = 0; e_wr = 0; e_inc = 0; e_ack = 0;
        end else begin
            adv = clock_en;
            if (m_sc == 2 && m_ph == 0) m_addr = r0;
            if (adv && m_ph == 1 && m_sc == 2 && m_dir_in) m_wdata = dma_wdata;
            if (adv && m_ph == 6) begin
                if (m_sc == 2 && !m_dir_in) m_rdata = mem_rdata;
                p_in = !dmai_n; p_out = !dmao_n; p_int = !int_n && ie;
                p_idle = idle; p_last = exec_last;
            end
            if (adv) begin
                if (m_ph == 7) begin
                    if (m_init)                   nsc = (p_in || p_out) ? 2 : 0;
                    else if (m_sc == 0)           nsc = 1;
                    else if (p_in || p_out)       nsc = 2;
                    else if (m_sc == 3)           nsc = 0;
                    else if (p_int)               nsc = 3;
                    else if (m_sc == 1)           nsc = (p_idle || !p_last) ? 1 : 0;
                    else                          nsc = p_idle ? 1 : 0;
                    if (nsc == 2) m_dir_in = p_in;
                    m_sc = nsc; m_init = 0; m_ph = 0;
                end else begin
                    m_ph = m_ph + 1;
                end
            end
            e_tpa = adv && m_ph == 1;
            e_tpb = adv && m_ph == 6;
            e_rd  = m_sc == 2 && !m_dir_in && m_ph >= 2 && m_ph <= 6;
            e_wr  = m_sc == 2 && m_dir_in && m_ph == 6;
            e_inc = adv && m_sc == 2 && m_ph == 7;
            e_ack = adv && m_sc == 3 && m_ph == 7;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock, compare all outputs, then let the modelled core bump R0.
    task automatic step();
        @(negedge clk);
        if (chk_en) begin
            chk("tpa", 32'(tpa), 32'(e_tpa));
            chk("tpb", 32'(tpb), 32'(e_tpb));
            chk("sc", 32'(sc), 32'(m_sc));
            chk("mem_rd", 32'(mem_rd), 32'(e_rd));
            chk("mem_wr", 32'(mem_wr), 32'(e_wr));
            chk("r0_inc", 32'(r0_inc), 32'(e_inc));
            chk("int_ack", 32'(int_ack), 32'(e_ack));
            chk("ie_clear", 32'(ie_clear), 32'(e_ack));
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            chk("dma_rdata", 32'(dma_rdata), 32'(m_rdata));
        end
        if (e_inc) r0 = r0 + 16'd1;
    endtask

    task automatic wait_state(input int want_sc, input int want_ph, input int budget,
                              input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(m_sc == want_sc && m_ph == want_ph) && n < budget);
        chk(name, 32'(sc), 32'(want_sc));
    endtask

    int cnt_a, cnt_b;

    initial begin
        repeat (3) step();
        chk_en = 1;
        chk("reset sc", 32'(sc), 32'd1);
        chk("reset mem_rd", 32'(mem_rd), 32'd0);

        // Init cycle then fetch; TPA/TPB positions and period.
        rst_n = 1'b1;
        step();
        chk("init tpa ph1", 32'(tpa), 32'd1);
        chk("init sc", 32'(sc), 32'd1);
        repeat (5) step();
        chk("init tpb ph6", 32'(tpb), 32'd1);
        repeat (2) step();
        chk("init -> S0", 32'(sc), 32'd0);
        step();
        chk("tpa period 8", 32'(tpa), 32'd1);

        // Single DMA-out.
        r0 = 16'h0100; mem_rdata = 8'hA5; dmao_n = 1'b0;
        wait_state(2, 1, 40, "dmao enter S2");
        chk("dmao addr", 32'(mem_addr), 32'h0100);
        dmao_n = 1'b1;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            cnt_a += int'(mem_rd);
            cnt_b += int'(r0_inc);
        end
        chk("dmao rd clocks", 32'(cnt_a), 32'd5);
        chk("dmao r0_inc once", 32'(cnt_b), 32'd1);
        chk("dmao rdata", 32'(dma_rdata), 32'hA5);
        chk("dmao -> S0", 32'(sc), 32'd0);

        // Eight back-to-back DMA-out cycles.
        r0 = 16'h0100; dmao_n = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wait_state(2, 1, 40, "burst S2");
            chk("burst addr", 32'(mem_addr), 32'h0100 + 32'(k));
            if (k == 7) dmao_n = 1'b1;
        end
        repeat (7) step();
        chk("burst -> S0", 32'(sc), 32'd0);

        // Interrupt entry, then interrupt masked by ie=0.
        ie = 1'b1; int_n = 1'b0;
        wait_state(3, 0, 40, "int enter S3");
        int_n = 1'b1;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            cnt_a += int'(int_ack);
            cnt_b += int'(ie_clear);
        end
        chk("int_ack once", 32'(cnt_a), 32'd1);
        chk("ie_clear once", 32'(cnt_b), 32'd1);
        chk("S3 -> S0", 32'(sc), 32'd0);
        ie = 1'b0; int_n = 1'b0;
        cnt_a = 0;
        for (int i = 0; i < 48; i++) begin
            step();
            cnt_a += (sc == 2'd3) ? 1 : 0;
        end
        chk("masked never S3", 32'(cnt_a), 32'd0);
        int_n = 1'b1;

        // Simultaneous DMA-in and DMA-out: in first, out next.
        dmai_n = 1'b0; dmao_n = 1'b0; dma_wdata = 8'h3C;
        wait_state(2, 0, 40, "both enter S2");
        dmai_n = 1'b1;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            cnt_a += int'(mem_wr);
            cnt_b += int'(mem_rd);
        end
        chk("dmai wr once", 32'(cnt_a), 32'd1);
        chk("dmai no rd", 32'(cnt_b), 32'd0);
        chk("dmai wdata", 32'(mem_wdata), 32'h3C);
        step();
        chk("dmao follows", 32'(sc), 32'd2);
        repeat (2) step();
        chk("dmao follows rd", 32'(mem_rd), 32'd1);
        dmao_n = 1'b1;

        // Reset in the middle of an S2.
        dmao_n = 1'b0;
        wait_state(2, 4, 40, "pre-reset S2");
        rst_n = 1'b0;
        step();
        chk("abort sc", 32'(sc), 32'd1);
        chk("abort mem_rd", 32'(mem_rd), 32'd0);
        rst_n = 1'b1; dmao_n = 1'b1;
        cnt_a = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            cnt_a += int'(r0_inc);
        end
        chk("abort no r0_inc", 32'(cnt_a), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            clock_en  = ($urandom % 8) != 0;
            dmao_n    = ($urandom % 16) >= 4;
            dmai_n    = ($urandom % 16) >= 2;
            int_n     = ($urandom % 8) >= 3;
            ie        = ($urandom % 4) != 0;
            idle      = ($urandom % 8) == 0;
            exec_last = ($urandom % 2) == 0;
            dma_wdata = 8'($urandom);
            mem_rdata = 8'($urandom);
            rst_n     = ($urandom % 400) != 0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
